bfm_apb_arbiter: RTL and testbench
==================================

# bfm_apb_arbiter

Round-robin arbiter and APB3 master sequencer that shares a single APB master port, normally the upstream side of the BFM APB-to-APB bridge, among NREQ simple requesters. Each requester presents a complete transfer (address, direction, write data) and receives a one-cycle completion pulse with read data and error status. The block owns the SETUP/ACCESS sequencing, wait-state handling and fairness, so BFM command engines never drive APB directly.

## Interface
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 255, ACCESS-phase watchdog limit in PCLK cycles (1..1023), used only with the timeout feature
- PCLK  in  1  single clock, rising edge
- PRESET  in  1  asynchronous, active-high reset
- REQ  in  NREQ  per-requester transfer request, level
- REQ_ADDR  in  NREQ*32  per-requester address, requester i at bits [32i+31:32i]
- REQ_WRITE  in  NREQ  per-requester direction, 1 = write
- REQ_WDATA  in  NREQ*32  per-requester write data, same packing as REQ_ADDR
- GNT  out  NREQ  one-hot owner of the current transfer, held from SETUP through completion
- DONE  out  NREQ  one-cycle completion pulse to the owner
- RDATA  out  32  read data captured at completion, valid with DONE, held until the next completion
- SLVERR  out  1  error status captured at completion, valid with DONE
- BUSY  out  1  high in SETUP or ACCESS
- PSEL, PENABLE, PWRITE  out  1 each  APB master controls
- PADDR, PWDATA  out  32 each  APB address and write data
- PRDATA  in  32, PREADY  in  1, PSLVERR  in  1  APB slave response

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE: arbitrate over REQ & ~DONE; the requester whose DONE is high is masked for that cycle. Winner = first set bit at or after (last_grant+1) mod NREQ. If there is a winner, latch its ADDR/WRITE/WDATA, set GNT, and go to SETUP.
- SETUP: PSEL=1, PENABLE=0; go unconditionally to ACCESS.
- ACCESS: PSEL=1, PENABLE=1; stay while PREADY=0. On PREADY=1: capture PRDATA into RDATA and PSLVERR into SLVERR, pulse DONE[owner], update last_grant=owner, clear GNT/PSEL/PENABLE, and return to IDLE.
- PADDR/PWRITE/PWDATA stay stable from SETUP through the completing cycle and are 0 in IDLE.
- REQ, REQ_ADDR, REQ_WRITE and REQ_WDATA are sampled only at grant. A requester that deasserts REQ during its transfer does not abort it.
- REQ still high in the cycle after DONE counts as a new request.
- Reset, including mid-transfer: all outputs 0, state IDLE, last_grant=NREQ-1 so requester 0 has first priority. A transfer in progress is abandoned and no DONE is issued.

## Timing
- REQ seen in IDLE at edge t -> SETUP at t+1 -> ACCESS at t+2. The earliest PREADY is sampled at t+3, and DONE is high in cycle t+3 to t+4.
- Minimum transfer is 3 cycles. Back-to-back transfers from different requesters have 1 IDLE cycle between them (the DONE cycle).
- All outputs are registered. There is no combinational path from APB inputs to outputs.
- PREADY and PSLVERR are ignored outside ACCESS.

## Configuration
- BFM_APBARB_TIMEOUT_EN defined: a 10-bit counter clears on SETUP and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT with PREADY still 0, the transfer completes exactly as on PREADY, except SLVERR=1 and RDATA=32'hDEAD_BEEF.
  - If PREADY and the timeout coincide, PREADY wins.
- Not defined: no counter, ACCESS waits indefinitely, and TIMEOUT is unused.

## Structure
- Package bfm_apbarb_pkg holds the state enum (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2), the timeout read-data constant and the counter width.
- Sub-module bfm_rr_arbiter is combinational round-robin pick from a request vector and pointer, giving a one-hot grant and a valid flag. The top level holds the pointer and FSM.

## Test plan
- Single write, NREQ=4: REQ[2]=1, ADDR=32'h0100_0010, WDATA=32'hA5A5_0001, PREADY tied 1 -> PSEL at t+1, PENABLE at t+2, DONE=4'b0100 at t+3, GNT=4'b0100 during transfer.
- Contention: REQ=4'b1111 held continuously after reset -> grant order 0,1,2,3,0, with a one-cycle gap per transfer.
- Wait states and read: REQ[1] read, PREADY low 5 ACCESS cycles, PRDATA=32'h1234_5678 -> PADDR stable for 6 ACCESS cycles, RDATA=32'h1234_5678 and SLVERR=0 with DONE[1].
- Error propagation: PSLVERR=1 with PREADY -> SLVERR=1 with DONE; the next transfer with PSLVERR=0 returns SLVERR=0.
- Reset mid-ACCESS: assert PRESET while PENABLE=1 -> all outputs 0 immediately, no DONE; the first post-reset grant with REQ=4'b1010 goes to requester 1.
- With BFM_APBARB_TIMEOUT_EN and TIMEOUT=8, PREADY held 0 -> DONE after 8 ACCESS cycles with SLVERR=1 and RDATA=32'hDEAD_BEEF.

Source files
------------

// File: rtl/bfm_apbarb_pkg.sv
// Shared types and constants for the APB round-robin arbiter.
// Holds the FSM state encoding, timeout read data and counter width.
package bfm_apbarb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
    localparam int          CNT_W         = 10;

endpackage

// File: rtl/bfm_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr+1.
// Produces a one-hot grant, its index and a valid flag.
module bfm_rr_arbiter
    import bfm_apbarb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    // Scan requesters starting just after the last owner, first hit wins.
    always_comb begin
        int c;
        c     = 0;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            c = (int'(ptr) + 1 + i) % NREQ;
            if (!valid && req[c]) begin
                gnt[c] = 1'b1;
                idx    = IW'(c);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bfm_apb_arbiter.sv
// Round-robin arbiter and APB3 master sequencer for NREQ requesters.
// Define BFM_APBARB_TIMEOUT_EN to enable the ACCESS-phase watchdog.
module bfm_apb_arbiter
    import bfm_apbarb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic [NREQ-1:0]      REQ,
    input  logic [NREQ*32-1:0]   REQ_ADDR,
    input  logic [NREQ-1:0]      REQ_WRITE,
    input  logic [NREQ*32-1:0]   REQ_WDATA,
    output logic [NREQ-1:0]      GNT,
    output logic [NREQ-1:0]      DONE,
    output logic [31:0]          RDATA,
    output logic                 SLVERR,
    output logic                 BUSY,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [31:0]          PADDR,
    output logic [31:0]          PWDATA,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);

    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 1023) begin : g_param_check
        $error("bfm_apb_arbiter: parameter out of range");
    end

    state_t            state_q, state_n;
    logic [NREQ-1:0]   gnt_q, gnt_n;
    logic [NREQ-1:0]   done_q, done_n;
    logic [31:0]       rdata_q, rdata_n;
    logic              slverr_q, slverr_n;
    logic              busy_q, busy_n;
    logic              psel_q, psel_n;
    logic              penable_q, penable_n;
    logic              pwrite_q, pwrite_n;
    logic [31:0]       paddr_q, paddr_n;
    logic [31:0]       pwdata_q, pwdata_n;
    logic [IW-1:0]     owner_q, owner_n;
    logic [IW-1:0]     last_q, last_n;
`ifdef BFM_APBARB_TIMEOUT_EN
    logic [CNT_W-1:0]  cnt_q, cnt_n;
`endif

    logic [NREQ-1:0]   arb_req;
    logic [NREQ-1:0]   arb_gnt;
    logic [IW-1:0]     arb_idx;
    logic              arb_valid;

    assign arb_req = REQ & ~done_q;

    bfm_rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req   (arb_req),
        .ptr   (last_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Next-state and next-output logic for the IDLE/SETUP/ACCESS sequencer.
    always_comb begin
        logic        fin;
        logic [31:0] fin_rdata;
        logic        fin_err;
        fin       = 1'b0;
        fin_rdata = TIMEOUT_RDATA;
        fin_err   = 1'b1;
        state_n   = state_q;
        gnt_n     = gnt_q;
        done_n    = '0;
        rdata_n   = rdata_q;
        slverr_n  = slverr_q;
        psel_n    = psel_q;
        penable_n = penable_q;
        pwrite_n  = pwrite_q;
        paddr_n   = paddr_q;
        pwdata_n  = pwdata_q;
        owner_n   = owner_q;
        last_n    = last_q;
`ifdef BFM_APBARB_TIMEOUT_EN
        cnt_n     = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_n  = SETUP;
                    gnt_n    = arb_gnt;
                    owner_n  = arb_idx;
                    psel_n   = 1'b1;
                    paddr_n  = REQ_ADDR[{arb_idx, 5'b0} +: 32];
                    pwdata_n = REQ_WDATA[{arb_idx, 5'b0} +: 32];
                    pwrite_n = REQ_WRITE[arb_idx];
                end
            end
            SETUP: begin
                state_n   = ACCESS;
                penable_n = 1'b1;
`ifdef BFM_APBARB_TIMEOUT_EN
                cnt_n     = '0;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    fin       = 1'b1;
                    fin_rdata = PRDATA;
                    fin_err   = PSLVERR;
                end
`ifdef BFM_APBARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    fin = 1'b1;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
`endif
                if (fin) begin
                    state_n   = IDLE;
                    rdata_n   = fin_rdata;
                    slverr_n  = fin_err;
                    done_n    = gnt_q;
                    last_n    = owner_q;
                    gnt_n     = '0;
                    psel_n    = 1'b0;
                    penable_n = 1'b0;
                    pwrite_n  = 1'b0;
                    paddr_n   = '0;
                    pwdata_n  = '0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // State and registered outputs; reset abandons any transfer in flight.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            slverr_q  <= 1'b0;
            busy_q    <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            owner_q   <= '0;
            last_q    <= IW'(NREQ - 1);
`ifdef BFM_APBARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_n;
            gnt_q     <= gnt_n;
            done_q    <= done_n;
            rdata_q   <= rdata_n;
            slverr_q  <= slverr_n;
            busy_q    <= busy_n;
            psel_q    <= psel_n;
            penable_q <= penable_n;
            pwrite_q  <= pwrite_n;
            paddr_q   <= paddr_n;
            pwdata_q  <= pwdata_n;
            owner_q   <= owner_n;
            last_q    <= last_n;
`ifdef BFM_APBARB_TIMEOUT_EN
            cnt_q     <= cnt_n;
`endif
        end
    end

    assign GNT     = gnt_q;
    assign DONE    = done_q;
    assign RDATA   = rdata_q;
    assign SLVERR  = slverr_q;
    assign BUSY    = busy_q;
    assign PSEL    = psel_q;
    assign PENABLE = penable_q;
    assign PWRITE  = pwrite_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_bfm_apb_arbiter.sv
// Directed testbench for bfm_apb_arbiter with NREQ=4.
// Timeout scenario runs only when BFM_APBARB_TIMEOUT_EN is defined.
module tb_bfm_apb_arbiter;

    localparam int NREQ = 4;
`ifdef BFM_APBARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic [NREQ-1:0]   REQ;
    logic [NREQ*32-1:0] REQ_ADDR;
    logic [NREQ-1:0]   REQ_WRITE;
    logic [NREQ*32-1:0] REQ_WDATA;
    logic [NREQ-1:0]   GNT;
    logic [NREQ-1:0]   DONE;
    logic [31:0]       RDATA;
    logic              SLVERR;
    logic              BUSY;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [31:0]       PADDR;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    int checks   = 0;
    int failures = 0;

    bfm_apb_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .REQ       (REQ),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WRITE (REQ_WRITE),
        .REQ_WDATA (REQ_WDATA),
        .GNT       (GNT),
        .DONE      (DONE),
        .RDATA     (RDATA),
        .SLVERR    (SLVERR),
        .BUSY      (BUSY),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic do_reset();
        PRESET = 1'b1;
        step();
        step();
        PRESET = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [31:0] a,
                           input logic w, input logic [31:0] d);
        REQ_ADDR[i*32 +: 32]  = a;
        REQ_WDATA[i*32 +: 32] = d;
        REQ_WRITE[i]          = w;
        REQ[i]                = 1'b1;
    endtask

    task automatic test_reset();
        step();
        checks++;
        if ({PSEL, PENABLE, PWRITE, BUSY, SLVERR} !== 5'b0 ||
            GNT !== 4'b0 || DONE !== 4'b0 ||
            PADDR !== 32'h0 || PWDATA !== 32'h0 || RDATA !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: psel=%b pen=%b gnt=%b done=%b busy=%b paddr=%h rdata=%h, all should be 0",
                     PSEL, PENABLE, GNT, DONE, BUSY, PADDR, RDATA);
        end
        PRESET = 1'b0;
    endtask

    task automatic test_single_write();
        PREADY = 1'b1;
        set_req(2, 32'h0100_0010, 1'b1, 32'hA5A5_0001);
        step();
        REQ = '0;
        checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b0 || GNT !== 4'b0100 ||
            BUSY !== 1'b1 || PWRITE !== 1'b1 ||
            PADDR !== 32'h0100_0010 || PWDATA !== 32'hA5A5_0001) begin
            failures++;
            $display("FAIL write_setup: psel=%b pen=%b gnt=%b busy=%b pwrite=%b paddr=%h pwdata=%h, need 1 0 0100 1 1 01000010 a5a50001",
                     PSEL, PENABLE, GNT, BUSY, PWRITE, PADDR, PWDATA);
        end
        step();
        checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b1 || GNT !== 4'b0100 ||
            DONE !== 4'b0 || PADDR !== 32'h0100_0010) begin
            failures++;
            $display("FAIL write_access: psel=%b pen=%b gnt=%b done=%b paddr=%h, need 1 1 0100 0000 01000010",
                     PSEL, PENABLE, GNT, DONE, PADDR);
        end
        step();
        checks++;
        if (DONE !== 4'b0100 || PSEL !== 1'b0 || PENABLE !== 1'b0 ||
            GNT !== 4'b0 || BUSY !== 1'b0 || PADDR !== 32'h0 ||
            PWDATA !== 32'h0 || PWRITE !== 1'b0) begin
            failures++;
            $display("FAIL write_done: done=%b psel=%b pen=%b gnt=%b busy=%b paddr=%h, need 0100 0 0 0000 0 0",
                     DONE, PSEL, PENABLE, GNT, BUSY, PADDR);
        end
        step();
        checks++;
        if (DONE !== 4'b0 || PSEL !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse: done=%b psel=%b, need 0000 0", DONE, PSEL);
        end
    endtask

    task automatic test_contention();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp;
        do_reset();
        PREADY = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 32'h2000_0000 + i, 1'b1, 32'h0);
        for (int k = 0; k < 5; k++) begin
            exp = 4'b0001 << order[k];
            step();
            checks++;
            if (GNT !== exp || PSEL !== 1'b1 || PENABLE !== 1'b0 ||
                PADDR !== 32'h2000_0000 + order[k]) begin
                failures++;
                $display("FAIL rr_grant[%0d]: gnt=%b psel=%b pen=%b paddr=%h, need %b 1 0 %h",
                         k, GNT, PSEL, PENABLE, PADDR, exp, 32'h2000_0000 + order[k]);
            end
            step();
            step();
            checks++;
            if (DONE !== exp || GNT !== 4'b0 || PSEL !== 1'b0) begin
                failures++;
                $display("FAIL rr_done[%0d]: done=%b gnt=%b psel=%b, need %b 0000 0",
                         k, DONE, GNT, PSEL, exp);
            end
        end
        REQ = '0;
        step();
    endtask

    task automatic test_wait_read();
        PREADY = 1'b0;
        PRDATA = 32'hFFFF_0000;
        set_req(1, 32'h0300_0044, 1'b0, 32'h0);
        step();
        REQ = '0;
        checks++;
        if (GNT !== 4'b0010 || PWRITE !== 1'b0 || PSEL !== 1'b1 ||
            PADDR !== 32'h0300_0044) begin
            failures++;
            $display("FAIL read_setup: gnt=%b pwrite=%b psel=%b paddr=%h, need 0010 0 1 03000044",
                     GNT, PWRITE, PSEL, PADDR);
        end
        step();
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (PENABLE !== 1'b1 || PSEL !== 1'b1 || DONE !== 4'b0 ||
                PADDR !== 32'h0300_0044 || GNT !== 4'b0010) begin
                failures++;
                $display("FAIL wait_access[%0d]: pen=%b psel=%b done=%b paddr=%h gnt=%b, need 1 1 0000 03000044 0010",
                         k, PENABLE, PSEL, DONE, PADDR, GNT);
            end
            if (k == 5) begin
                PREADY = 1'b1;
                PRDATA = 32'h1234_5678;
            end
            step();
        end
        PRDATA = 32'h0BAD_0BAD;
        checks++;
        if (DONE !== 4'b0010 || RDATA !== 32'h1234_5678 || SLVERR !== 1'b0) begin
            failures++;
            $display("FAIL read_done: done=%b rdata=%h slverr=%b, need 0010 12345678 0",
                     DONE, RDATA, SLVERR);
        end
        step();
        checks++;
        if (RDATA !== 32'h1234_5678 || DONE !== 4'b0) begin
            failures++;
            $display("FAIL rdata_hold: rdata=%h done=%b, need 12345678 0000", RDATA, DONE);
        end
    endtask

    task automatic test_error();
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        set_req(3, 32'h0400_0000, 1'b1, 32'h5555_AAAA);
        step();
        REQ = '0;
        step();
        step();
        PSLVERR = 1'b0;
        checks++;
        if (DONE !== 4'b1000 || SLVERR !== 1'b1) begin
            failures++;
            $display("FAIL err_done: done=%b slverr=%b, need 1000 1", DONE, SLVERR);
        end
        set_req(1, 32'h0400_0004, 1'b1, 32'h0000_0001);
        step();
        REQ = '0;
        checks++;
        if (GNT !== 4'b0010) begin
            failures++;
            $display("FAIL err_next_grant: gnt=%b, need 0010", GNT);
        end
        step();
        step();
        checks++;
        if (DONE !== 4'b0010 || SLVERR !== 1'b0) begin
            failures++;
            $display("FAIL err_clear: done=%b slverr=%b, need 0010 0", DONE, SLVERR);
        end
        step();
    endtask

    task automatic test_reset_mid();
        PREADY = 1'b0;
        set_req(2, 32'h0500_0000, 1'b1, 32'h7777_7777);
        step();
        REQ = '0;
        step();
        checks++;
        if (PENABLE !== 1'b1 || GNT !== 4'b0100) begin
            failures++;
            $display("FAIL mid_access: pen=%b gnt=%b, need 1 0100", PENABLE, GNT);
        end
        PRESET = 1'b1;
        #1;
        checks++;
        if ({PSEL, PENABLE, PWRITE, BUSY, SLVERR} !== 5'b0 ||
            GNT !== 4'b0 || DONE !== 4'b0 || PADDR !== 32'h0 ||
            PWDATA !== 32'h0 || RDATA !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset_outputs: psel=%b pen=%b gnt=%b done=%b busy=%b paddr=%h rdata=%h, all should be 0",
                     PSEL, PENABLE, GNT, DONE, BUSY, PADDR, RDATA);
        end
        PREADY = 1'b1;
        step();
        checks++;
        if (DONE !== 4'b0 || PSEL !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_no_done: done=%b psel=%b, need 0000 0", DONE, PSEL);
        end
        REQ = 4'b1010;
        REQ_ADDR[1*32 +: 32] = 32'h0600_0001;
        REQ_ADDR[3*32 +: 32] = 32'h0600_0003;
        PRESET = 1'b0;
        step();
        checks++;
        if (GNT !== 4'b0010 || PADDR !== 32'h0600_0001) begin
            failures++;
            $display("FAIL post_reset_grant: gnt=%b paddr=%h, need 0010 06000001", GNT, PADDR);
        end
        REQ = '0;
        step();
        step();
        step();
    endtask

`ifdef BFM_APBARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        PREADY = 1'b0;
        PRDATA = 32'h1111_2222;
        set_req(0, 32'h0700_0000, 1'b0, 32'h0);
        step();
        REQ = '0;
        step();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (PENABLE !== 1'b1 || DONE !== 4'b0) begin
                failures++;
                $display("FAIL to_wait[%0d]: pen=%b done=%b, need 1 0000", k, PENABLE, DONE);
            end
            step();
        end
        checks++;
        if (DONE !== 4'b0001 || SLVERR !== 1'b1 || RDATA !== 32'hDEAD_BEEF ||
            PSEL !== 1'b0) begin
            failures++;
            $display("FAIL to_done: done=%b slverr=%b rdata=%h psel=%b, need 0001 1 deadbeef 0",
                     DONE, SLVERR, RDATA, PSEL);
        end
    endtask
`endif

    initial begin
        PRESET    = 1'b1;
        REQ       = '0;
        REQ_ADDR  = '0;
        REQ_WRITE = '0;
        REQ_WDATA = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        test_reset();
        test_single_write();
        test_contention();
        test_wait_read();
        test_error();
        test_reset_mid();
`ifdef BFM_APBARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
